// File: rtl/child_slot_scheduler.sv
// Round-robin owner of one shared execution slot across N_CHILD leaf children, with watchdog reclaim.
// Latency: grant registered one edge after req is seen in IDLE; two dead cycles between grants.
module child_slot_scheduler #(
    parameter int N_CHILD = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [N_CHILD-1:0]         req,
    input  logic [N_CHILD-1:0]         done,
    output logic [N_CHILD-1:0]         grant,
    output logic                       busy,
    output logic [$clog2(N_CHILD)-1:0] active_idx,
    output logic                       timeout_pulse,
    output logic [CNT_W-1:0]           grant_count
);
    localparam int IDX_W = $clog2(N_CHILD);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_CHILD-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tpulse_q, tpulse_d;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   ptr_next;
    int                 cand;

    // First requester at or above ptr, wrapping back to child 0.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int i = 0; i < N_CHILD; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N_CHILD) begin
                cand = cand - N_CHILD;
            end
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    assign ptr_next = (idx_q == IDX_W'(N_CHILD - 1)) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        tmr_d    = tmr_q;
        cnt_d    = cnt_q;
        tpulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && sel_found) begin
                    grant_d = N_CHILD'(1) << sel_idx;
                    idx_d   = sel_idx;
                    tmr_d   = '0;
                    state_d = S_GRANT;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_GRANT: begin
                // done takes priority so a release on the final cycle is not reported as a timeout
                if (done[idx_q]) begin
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = S_RELEASE;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    grant_d  = '0;
                    ptr_d    = ptr_next;
                    tpulse_d = 1'b1;
                    state_d  = S_RELEASE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            tmr_q    <= '0;
            cnt_q    <= '0;
            tpulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            tpulse_q <= tpulse_d;
        end
    end

    assign grant         = grant_q;
    assign busy          = (state_q != S_IDLE);
    assign active_idx    = idx_q;
    assign timeout_pulse = tpulse_q;
    assign grant_count   = cnt_q;

endmodule

// File: tb/tb_child_slot_scheduler.sv
// Directed bench for child_slot_scheduler; a second instance with a 3-bit counter checks saturation.
module tb_child_slot_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [4:0] req;
    logic [4:0] done;
    logic [4:0] grant;
    logic       busy;
    logic [2:0] active_idx;
    logic       timeout_pulse;
    logic [7:0] grant_count;
    logic [4:0] grant2;
    logic       busy2;
    logic [2:0] active_idx2;
    logic       timeout_pulse2;
    logic [2:0] grant_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    child_slot_scheduler #(.N_CHILD(5), .TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .done(done),
        .grant(grant), .busy(busy), .active_idx(active_idx),
        .timeout_pulse(timeout_pulse), .grant_count(grant_count)
    );

    child_slot_scheduler #(.N_CHILD(5), .TIMEOUT(16), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .done(done),
        .grant(grant2), .busy(busy2), .active_idx(active_idx2),
        .timeout_pulse(timeout_pulse2), .grant_count(grant_count2)
    );

    task automatic do_reset;
        req    = '0;
        done   = '0;
        enable = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
    endtask

    task automatic wait_grant(input int limit, output int n);
        n = 0;
        while (grant === 5'b00000 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        req    = '0;
        done   = '0;
        enable = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (grant !== 5'b00000) begin errors++; $display("FAIL reset_grant: got %b expected 00000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (active_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", active_idx); end
        checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_tpulse: got %b expected 0", timeout_pulse); end
        checks++; if (grant_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", grant_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        int n;
        do_reset();
        enable = 1'b1;
        req    = 5'b00100;
        wait_grant(8, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", n); end
        checks++; if (grant !== 5'b00100) begin errors++; $display("FAIL single_grant: got %b expected 00100", grant); end
        checks++; if (active_idx !== 3'd2) begin errors++; $display("FAIL single_idx: got %0d expected 2", active_idx); end
        checks++; if (grant_count !== 8'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", grant_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (grant !== 5'b00100) begin errors++; $display("FAIL single_hold: got %b expected 00100", grant); end
        done = 5'b00100;
        @(negedge clk);
        done = '0;
        req  = '0;
        checks++; if (grant !== 5'b00000) begin errors++; $display("FAIL single_release: got %b expected 00000", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rel: got %b expected 1", busy); end
        checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL single_tpulse: got %b expected 0", timeout_pulse); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", busy); end
        checks++; if (active_idx !== 3'd2) begin errors++; $display("FAIL single_idx_hold: got %0d expected 2", active_idx); end
    endtask

    task automatic test_contention;
        int n;
        logic [4:0] expg;
        do_reset();
        enable = 1'b1;
        req    = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            expg = 5'b00001 << (k % 5);
            wait_grant(8, n);
            checks++; if (n !== ((k == 0) ? 1 : 2)) begin errors++; $display("FAIL cont_gap%0d: got %0d expected %0d", k, n, (k == 0) ? 1 : 2); end
            checks++; if (grant !== expg) begin errors++; $display("FAIL cont_grant%0d: got %b expected %b", k, grant, expg); end
            checks++; if (active_idx !== 3'(k % 5)) begin errors++; $display("FAIL cont_idx%0d: got %0d expected %0d", k, active_idx, k % 5); end
            done = grant;
            @(negedge clk);
            done = '0;
        end
        req = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_watchdog;
        int n;
        int hold;
        do_reset();
        enable = 1'b1;
        req    = 5'b00001;
        wait_grant(8, n);
        hold = 0;
        while (grant === 5'b00001 && hold < 40) begin
            hold++;
            @(negedge clk);
        end
        checks++; if (hold !== 16) begin errors++; $display("FAIL wd_hold: got %0d expected 16", hold); end
        checks++; if (timeout_pulse !== 1'b1) begin errors++; $display("FAIL wd_pulse: got %b expected 1", timeout_pulse); end
        req = 5'b00011;
        @(negedge clk);
        checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL wd_pulse_width: got %b expected 0", timeout_pulse); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle: got %b expected 0", busy); end
        wait_grant(8, n);
        checks++; if (grant !== 5'b00010) begin errors++; $display("FAIL wd_ptr_advance: got %b expected 00010", grant); end
        done = 5'b00010;
        @(negedge clk);
        done = '0;
        req  = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_collision;
        int n;
        int bad;
        do_reset();
        enable = 1'b1;
        req    = 5'b00001;
        wait_grant(8, n);
        done = 5'b00010;
        @(negedge clk);
        done = '0;
        bad  = 0;
        for (int c = 2; c < 16; c++) begin
            if (grant !== 5'b00001) bad++;
            @(negedge clk);
        end
        if (grant !== 5'b00001) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL coll_hold: got %0d bad cycles expected 0", bad); end
        done = 5'b00001;
        @(negedge clk);
        done = '0;
        req  = '0;
        checks++; if (grant !== 5'b00000) begin errors++; $display("FAIL coll_release: got %b expected 00000", grant); end
        checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL coll_tpulse: got %b expected 0", timeout_pulse); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coll_busy: got %b expected 1", busy); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_enable_reset;
        int n;
        int bad;
        do_reset();
        enable = 1'b1;
        req    = 5'b11111;
        wait_grant(8, n);
        checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL en_first: got %b expected 00001", grant); end
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL en_hold: got %b expected 00001", grant); end
        done = 5'b00001;
        @(negedge clk);
        done = '0;
        bad  = 0;
        repeat (6) begin
            @(negedge clk);
            if (grant !== 5'b00000) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL en_blocked: got %0d granted cycles expected 0", bad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_idle: got %b expected 0", busy); end
        enable = 1'b1;
        wait_grant(8, n);
        checks++; if (grant !== 5'b00010) begin errors++; $display("FAIL en_resume: got %b expected 00010", grant); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (grant !== 5'b00000) begin errors++; $display("FAIL rst_grant: got %b expected 00000", grant); end
        checks++; if (grant_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", grant_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (active_idx !== 3'd0) begin errors++; $display("FAIL rst_idx: got %0d expected 0", active_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant(8, n);
        checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL rst_first_grant: got %b expected 00001", grant); end
        checks++; if (n !== 1) begin errors++; $display("FAIL rst_latency: got %0d expected 1", n); end
        done = 5'b00001;
        @(negedge clk);
        done = '0;
        req  = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_saturation;
        int n;
        int missed;
        do_reset();
        enable = 1'b1;
        req    = 5'b00100;
        missed = 0;
        for (int g = 0; g < 10; g++) begin
            wait_grant(8, n);
            if (grant === 5'b00000) missed++;
            done = 5'b00100;
            @(negedge clk);
            done = '0;
        end
        req = '0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (missed !== 0) begin errors++; $display("FAIL sat_grants: got %0d missed expected 0", missed); end
        checks++; if (grant_count !== 8'd10) begin errors++; $display("FAIL sat_count8: got %0d expected 10", grant_count); end
        checks++; if (grant_count2 !== 3'd7) begin errors++; $display("FAIL sat_count3: got %0d expected 7", grant_count2); end
    endtask

    // popcount(grant) must never exceed one
    always @(negedge clk) begin
        if (rst_n === 1'b1 && $countones(grant) > 1) begin
            errors++;
            $display("FAIL onehot: got %b expected at most one bit", grant);
        end
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_watchdog();
        test_collision();
        test_enable_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/child_slot_scheduler.md
# child_slot_scheduler

Round-robin scheduler that shares one execution slot among the five leaf child instances of a subtree node (child indices 0..4). Each child raises a request, receives an exclusive one-hot grant, and releases it with a done pulse. A watchdog reclaims the slot from any child that holds it too long. The block sits beside the child instances inside the parent node and drives their grant inputs.

## Interface
Parameters:
- N_CHILD, 5: number of requesting children (2..8).
- TIMEOUT, 16: maximum grant length in cycles (≥2).
- CNT_W, 8: width of the grant counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  allows new grants while high.
- req  input  N_CHILD  per-child request level.
- done  input  N_CHILD  per-child release pulse; only the bit of the granted child is honoured.
- grant  output  N_CHILD  one-hot or zero grant, registered.
- busy  output  1  high whenever the state is not IDLE.
- active_idx  output  $clog2(N_CHILD)  index of the current or last granted child.
- timeout_pulse  output  1  one-cycle pulse when a grant is reclaimed by the watchdog.
- grant_count  output  CNT_W  total grants issued, saturating.

## Operation
- Reset values:
  - grant=0, busy=0, active_idx=0, timeout_pulse=0, grant_count=0.
  - Internal: state=IDLE, round-robin pointer ptr=0, timer=0.
- IDLE:
  - If enable=1 and req≠0, select the first set req bit searching upward from ptr, wrapping N_CHILD-1→0.
  - Assert grant[sel], set active_idx=sel, increment grant_count, clear timer, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - Hold grant and increment timer each cycle.
  - If done[active_idx]=1: clear grant and go to RELEASE.
  - Else if timer==TIMEOUT-1: clear grant, pulse timeout_pulse, go to RELEASE.
  - In both cases set ptr=(active_idx+1) mod N_CHILD.
- RELEASE:
  - One dead cycle with grant=0, then go to IDLE.
- Boundary rules:
  - done and timeout on the same edge: done wins, no timeout_pulse.
  - done bits of non-granted children are ignored in every state.
  - A granted child dropping req mid-grant is ignored; the grant is held until done or timeout.
  - enable falling mid-grant: the current grant completes normally; no new grant issues until enable returns.
  - grant_count saturates at 2^CNT_W-1.
  - Asynchronous reset mid-grant: grant drops immediately and all state returns to its reset values.
- Invariant: popcount(grant)≤1 at all times.

## Timing
- Request latency: req sampled in IDLE at edge E0 → grant high from E0 onward (1-cycle registered latency).
- Release: done sampled at edge Ed → grant low after Ed; RELEASE occupies Ed..Ed+1; IDLE from Ed+1.
- Earliest next grant: after Ed+2, so the minimum gap between grants is 2 cycles.
- Maximum hold: grant is high for exactly TIMEOUT cycles before watchdog reclaim; timeout_pulse is high for the single cycle following that edge.
- busy: high from the grant edge through the RELEASE cycle.
- active_idx: updates on the grant edge and holds until the next grant.

## Test plan
- Single requester: req=5'b00100, done pulsed 3 cycles after grant → grant=00100 for 3 cycles, active_idx=2, grant_count=1, no timeout_pulse.
- Full contention: req=5'b11111 held, each child pulses done 1 cycle after its grant → grant order 0,1,2,3,4,0 with a 2-cycle gap between grants.
- Watchdog: req=00001 and done never asserted, TIMEOUT=16 → grant held exactly 16 cycles, then timeout_pulse for 1 cycle, ptr advances to 1.
- Done/timeout collision: done[active] asserted on the timer==15 edge → release with timeout_pulse=0. A done pulse on a non-granted child bit has no effect.
- Enable and reset: enable drops mid-grant → current grant completes, then no grant while req=11111. rst_n asserted mid-grant → grant=0 immediately, grant_count=0, and after release the first grant goes to child 0.
- Saturation: CNT_W=3, 10 grants issued → grant_count stops at 7.
